// File: rtl/stopwatch_adj_core.sv
// Minutes/seconds stopwatch core with run/pause/expired states, up/down run
// counting and per-field adjust, all qualified by single-cycle enable ticks.
module stopwatch_adj_core #(
    parameter int SEC_MOD = 60,
    parameter int MIN_MOD = 60,
    parameter int SEC_W   = 6,
    parameter int MIN_W   = 6,
    parameter bit RST_RUN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_run,
    input  logic             tick_adj,
    input  logic             adj,
    input  logic             sel,
    input  logic             pause_tgl,
    input  logic             dir,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic             paused,
    output logic             expired,
    output logic             carry_pulse
);

    typedef enum logic [1:0] {
        ST_RUNNING = 2'd0,
        ST_PAUSED  = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(SEC_MOD - 1);
    localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(MIN_MOD - 1);
    localparam logic [SEC_W-1:0] SEC_ONE = SEC_W'(1);
    localparam logic [MIN_W-1:0] MIN_ONE = MIN_W'(1);
    localparam state_t           RST_STATE = RST_RUN ? ST_RUNNING : ST_PAUSED;

    state_t           state_q, state_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic             carry_q, carry_d;

    logic             sec_wrap;
    logic             min_wrap;
    logic             hit_zero;

    always_comb begin
        state_d  = state_q;
        sec_d    = sec_q;
        min_d    = min_q;
        carry_d  = 1'b0;
        sec_wrap = (sec_q == SEC_MAX);
        min_wrap = (min_q == MIN_MAX);
        hit_zero = 1'b0;

        if (adj) begin
            // Adjust mode: no run counting, no pause toggling, no inter-field carry.
            if (tick_adj) begin
                if (sel) begin
                    sec_d = sec_wrap ? '0 : sec_q + SEC_ONE;
                end else begin
                    min_d = min_wrap ? '0 : min_q + MIN_ONE;
                end
                if (state_q == ST_EXPIRED) begin
                    state_d = ST_PAUSED;
                end
            end
        end else begin
            if (tick_run && state_q == ST_RUNNING) begin
                if (!dir) begin
                    sec_d = sec_wrap ? '0 : sec_q + SEC_ONE;
                    if (sec_wrap) begin
                        min_d   = min_wrap ? '0 : min_q + MIN_ONE;
                        carry_d = min_wrap;
                    end
                end else if (sec_q != '0) begin
                    sec_d    = sec_q - SEC_ONE;
                    hit_zero = (sec_q == SEC_ONE) && (min_q == '0);
                end else if (min_q != '0) begin
                    sec_d = SEC_MAX;
                    min_d = min_q - MIN_ONE;
                end else begin
                    hit_zero = 1'b1;
                end
            end

            // Expiry outranks a pause toggle landing on the same edge.
            if (hit_zero) begin
                state_d = ST_EXPIRED;
            end else if (pause_tgl && state_q == ST_RUNNING) begin
                state_d = ST_PAUSED;
            end else if (pause_tgl && state_q == ST_PAUSED) begin
                state_d = ST_RUNNING;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            sec_q   <= '0;
            min_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            carry_q <= carry_d;
        end
    end

    assign minutes     = min_q;
    assign seconds     = sec_q;
    assign carry_pulse = carry_q;
    assign paused      = (state_q == ST_PAUSED);
    assign expired     = (state_q == ST_EXPIRED);

endmodule

// File: tb/tb_stopwatch_adj_core.sv
// Directed bench for stopwatch_adj_core: a default 60/60 instance and a
// 10/24 instance that resets into PAUSED.
module tb_stopwatch_adj_core;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       tick_run = 0, tick_adj = 0, adj = 0, sel = 0, pause_tgl = 0, dir = 0;
    logic [5:0] minutes, seconds;
    logic       paused, expired, carry_pulse;

    logic       b_tick_run = 0, b_tick_adj = 0, b_adj = 0, b_sel = 0, b_pause_tgl = 0, b_dir = 0;
    logic [4:0] b_minutes;
    logic [3:0] b_seconds;
    logic       b_paused, b_expired, b_carry_pulse;

    int vecs = 0;
    int errs = 0;
    int carry_cnt = 0;
    int b_carry_cnt = 0;

    always #5 clk = ~clk;

    stopwatch_adj_core dut_a (
        .clk(clk), .rst(rst), .tick_run(tick_run), .tick_adj(tick_adj), .adj(adj),
        .sel(sel), .pause_tgl(pause_tgl), .dir(dir), .minutes(minutes), .seconds(seconds),
        .paused(paused), .expired(expired), .carry_pulse(carry_pulse)
    );

    stopwatch_adj_core #(
        .SEC_MOD(10), .MIN_MOD(24), .SEC_W(4), .MIN_W(5), .RST_RUN(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .tick_run(b_tick_run), .tick_adj(b_tick_adj), .adj(b_adj),
        .sel(b_sel), .pause_tgl(b_pause_tgl), .dir(b_dir), .minutes(b_minutes),
        .seconds(b_seconds), .paused(b_paused), .expired(b_expired),
        .carry_pulse(b_carry_pulse)
    );

    always @(posedge clk) begin
        if (carry_pulse)   carry_cnt   <= carry_cnt + 1;
        if (b_carry_pulse) b_carry_cnt <= b_carry_cnt + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_ticks(input int n);
        repeat (n) begin
            @(negedge clk); tick_run = 1'b1;
            @(negedge clk); tick_run = 1'b0;
        end
    endtask

    task automatic adj_ticks(input int n);
        repeat (n) begin
            @(negedge clk); tick_adj = 1'b1;
            @(negedge clk); tick_adj = 1'b0;
        end
    endtask

    task automatic toggle_pause();
        @(negedge clk); pause_tgl = 1'b1;
        @(negedge clk); pause_tgl = 1'b0;
    endtask

    task automatic b_run_ticks(input int n);
        repeat (n) begin
            @(negedge clk); b_tick_run = 1'b1;
            @(negedge clk); b_tick_run = 1'b0;
        end
    endtask

    task automatic b_adj_ticks(input int n);
        repeat (n) begin
            @(negedge clk); b_tick_adj = 1'b1;
            @(negedge clk); b_tick_adj = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_min", minutes, 0);
        check("rst_sec", seconds, 0);
        check("rst_paused", paused, 0);
        check("rst_expired", expired, 0);
        check("rst_carry", carry_pulse, 0);
        check("b_rst_paused", b_paused, 1);
        @(negedge clk); rst = 1'b0;

        // 61 up-count ticks
        run_ticks(61);
        check("up61_min", minutes, 1);
        check("up61_sec", seconds, 1);
        check("up61_paused", paused, 0);
        check("up61_carry_cnt", carry_cnt, 0);

        // Preload 59:59 then roll over
        adj = 1'b1; sel = 1'b1; adj_ticks(58);
        sel = 1'b0; adj_ticks(58);
        adj = 1'b0;
        check("pre_min", minutes, 59);
        check("pre_sec", seconds, 59);
        run_ticks(1);
        check("roll_min", minutes, 0);
        check("roll_sec", seconds, 0);
        check("roll_carry_hi", carry_pulse, 1);
        @(negedge clk);
        check("roll_carry_lo", carry_pulse, 0);
        @(negedge clk);
        check("roll_carry_cnt", carry_cnt, 1);

        // Countdown from 00:02 to expiry
        adj = 1'b1; sel = 1'b1; adj_ticks(2); adj = 1'b0;
        dir = 1'b1;
        run_ticks(1);
        check("dn1_sec", seconds, 1);
        check("dn1_expired", expired, 0);
        run_ticks(1);
        check("dn0_sec", seconds, 0);
        check("dn0_min", minutes, 0);
        check("dn0_expired", expired, 1);
        run_ticks(2);
        toggle_pause();
        check("exp_hold_sec", seconds, 0);
        check("exp_hold_expired", expired, 1);
        check("exp_hold_paused", paused, 0);
        adj = 1'b1; sel = 1'b1; adj_ticks(1); adj = 1'b0;
        check("exp_adj_sec", seconds, 1);
        check("exp_adj_expired", expired, 0);
        check("exp_adj_paused", paused, 1);

        // Field-local adjust wraps from 05:59
        adj = 1'b1; sel = 1'b1; adj_ticks(58);
        sel = 1'b0; adj_ticks(5);
        check("a559_min", minutes, 5);
        check("a559_sec", seconds, 59);
        sel = 1'b1; adj_ticks(1);
        check("asec_wrap_sec", seconds, 0);
        check("asec_wrap_min", minutes, 5);
        sel = 1'b0; adj_ticks(55);
        check("amin_wrap_min", minutes, 0);
        check("amin_wrap_sec", seconds, 0);
        run_ticks(3);
        check("adj_run_drop_sec", seconds, 0);
        check("adj_run_drop_min", minutes, 0);
        check("adj_still_paused", paused, 1);

        // Pause toggle coinciding with a run tick
        sel = 1'b1; adj_ticks(10); adj = 1'b0;
        dir = 1'b0;
        toggle_pause();
        check("resume_paused", paused, 0);
        @(negedge clk); pause_tgl = 1'b1; tick_run = 1'b1;
        @(negedge clk); pause_tgl = 1'b0; tick_run = 1'b0;
        check("tgl_tick_sec", seconds, 11);
        check("tgl_tick_paused", paused, 1);
        run_ticks(3);
        check("paused_hold_sec", seconds, 11);
        toggle_pause();
        check("unpause", paused, 0);
        run_ticks(1);
        check("unpause_tick_sec", seconds, 12);
        adj_ticks(1);
        check("adj_low_ignored", seconds, 12);

        // Asynchronous reset between edges
        run_ticks(3);
        check("pre_rst_sec", seconds, 15);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("arst_sec", seconds, 0);
        check("arst_min", minutes, 0);
        check("arst_paused", paused, 0);
        @(negedge clk); rst = 1'b0;

        // Narrow-modulus instance
        check("b_paused_after_rst", b_paused, 1);
        b_run_ticks(2);
        check("b_paused_no_count", b_seconds, 0);
        @(negedge clk); b_pause_tgl = 1'b1;
        @(negedge clk); b_pause_tgl = 1'b0;
        b_run_ticks(9);
        check("b_sec9", b_seconds, 9);
        b_run_ticks(1);
        check("b_secwrap_sec", b_seconds, 0);
        check("b_secwrap_min", b_minutes, 1);
        b_adj = 1'b1; b_sel = 1'b0; b_adj_ticks(22); b_adj = 1'b0;
        check("b_min23", b_minutes, 23);
        b_run_ticks(9);
        check("b_2309_sec", b_seconds, 9);
        b_run_ticks(1);
        check("b_roll_min", b_minutes, 0);
        check("b_roll_sec", b_seconds, 0);
        check("b_roll_carry", b_carry_pulse, 1);
        @(negedge clk); @(negedge clk);
        check("b_carry_cnt", b_carry_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
